// File: rtl/fir_fixed_pkg.sv
// Shared FIR datapath constants and types (multiplier wrapper, tap sequencer, accumulator).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_fixed_pkg;

    localparam int PROD_W  = 36;   // signed 24s x 12s product
    localparam int ACC_W   = 40;   // 4 guard bits: up to 16 taps per sample
    localparam int OUT_W   = 24;   // output sample width
    localparam int SHIFT   = 11;   // coefficient fractional bits dropped at output
    localparam int MUL_LAT = 3;    // ce-qualified edges from operands to product

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [OUT_W-1:0]  sample_t;

    // Per-tap tag travelling alongside the multiplier pipeline
    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

    // Sign-extend a product to accumulator width
    function automatic acc_t sext_prod(prod_t p);
        return acc_t'(p);
    endfunction

endpackage

// File: rtl/fir_fixed_acc_round_if.sv
// Tap-in / sample-out bus between multiplier, accumulator and consumer.
// Latency: n/a (wiring only).
// Backpressure: in_ready from accumulator, out_ready from consumer.
interface fir_fixed_acc_round_if;
    import fir_fixed_pkg::*;

    logic    in_ready;
    logic    in_valid;
    logic    in_last;
    prod_t   prod;
    logic    out_valid;
    logic    out_ready;
    sample_t out_data;

    // Upstream/consumer side
    modport master (
        output in_valid, in_last, prod, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Accumulator side
    modport slave (
        input  in_valid, in_last, prod, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/fir_fixed_round_sat.sv
// Round half toward +inf, arithmetic shift by SHIFT, saturate ACC_W sum to OUT_W.
// Latency: combinational.
// Backpressure: none (pure function of its input).
module fir_fixed_round_sat
    import fir_fixed_pkg::*;
(
    input  acc_t    acc,
    output sample_t data,
    output logic    sat
);

    // One extra bit so the rounding bias can never wrap the sum
    localparam int RW = ACC_W + 1;
    localparam logic signed [RW-1:0] HALF  = RW'(1) <<< (SHIFT - 1);
    localparam logic signed [RW-1:0] MAX_V = (RW'(1) <<< (OUT_W - 1)) - RW'(1);
    localparam logic signed [RW-1:0] MIN_V = -(RW'(1) <<< (OUT_W - 1));

    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] shifted;

    assign biased  = {acc[ACC_W-1], acc} + HALF;
    assign shifted = biased >>> SHIFT;

    // Clip to the output range and flag any clipping
    always_comb begin
        sat  = 1'b0;
        data = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            sat  = 1'b1;
            data = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < MIN_V) begin
            sat  = 1'b1;
            data = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fir_fixed_acc_round.sv
// Accumulates tap products per output sample, then rounds/saturates into a registered result.
// Latency: last tap operands at cycle t -> out_valid at t+MUL_LAT+1 (ce high, no stall).
// Backpressure: held result not taken stalls mul_ce/in_ready; tags and multiplier freeze together.
module fir_fixed_acc_round
    import fir_fixed_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    output logic                  mul_ce,
    output logic [15:0]           sat_cnt,
    fir_fixed_acc_round_if.slave  bus
);

    tag_t [MUL_LAT-1:0] tags;
    tag_t               tag_in;
    tag_t               tag_out;
    acc_t               acc;
    acc_t               acc_next;
    logic               first;
    logic               stall;
    logic               adv;
    logic               load;
    logic               out_valid_q;
    sample_t            out_data_q;
    sample_t            rs_data;
    logic               rs_sat;

    assign stall   = out_valid_q & ~bus.out_ready;
    assign adv     = ce & ~stall;
    assign mul_ce  = adv;
    assign tag_in  = '{vld: bus.in_valid, last: bus.in_last};
    assign tag_out = tags[MUL_LAT-1];
    assign load    = adv & tag_out.vld & tag_out.last;

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Sum so far plus the product currently aligned with the last tag stage
    always_comb begin
        acc_next = (first ? '0 : acc) + sext_prod(bus.prod);
    end

    fir_fixed_round_sat u_round_sat (
        .acc  (acc_next),
        .data (rs_data),
        .sat  (rs_sat)
    );

    // Tag delay line mirrors the multiplier pipeline, advancing with mul_ce
    always_ff @(posedge clk) begin
        if (reset) begin
            tags <= '0;
        end else if (adv) begin
            tags <= {tags[MUL_LAT-2:0], tag_in};
        end
    end

    // Per-sample accumulation; invalid tags (bubbles) leave the sum alone
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            first <= 1'b1;
        end else if (adv && tag_out.vld) begin
            if (tag_out.last) begin
                acc   <= '0;
                first <= 1'b1;
            end else begin
                acc   <= acc_next;
                first <= 1'b0;
            end
        end
    end

    // Output register: load on a finished sample, clear on accept, ignore ce
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_cnt     <= '0;
        end else begin
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= rs_data;
                if (rs_sat && sat_cnt != 16'hFFFF) begin
                    sat_cnt <= sat_cnt + 16'd1;
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
